// File: rtl/hazard_pkg.sv
// Types and helpers shared by the ID decoder and the hazard interlock:
// late-producer record, divider FSM states and the GPR address width.
package hazard_pkg;

    localparam int unsigned GPR_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [GPR_AW-1:0] addr;
    } late_rec_t;

    typedef enum logic [0:0] {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    // $0 is hardwired, so a producer targeting it never creates a dependency.
    function automatic logic late_hit(
        input late_rec_t         rec,
        input logic              rs_used,
        input logic [GPR_AW-1:0] rs_addr,
        input logic              rt_used,
        input logic [GPR_AW-1:0] rt_addr
    );
        late_hit = rec.valid && (rec.addr != 5'd0) &&
                   ((rs_used && (rec.addr == rs_addr)) ||
                    (rt_used && (rec.addr == rt_addr)));
    endfunction

endpackage

// File: rtl/hazard_div_seq.sv
// Divider occupancy sequencer: tracks how long a div/divu keeps EXE busy
// and exposes a registered busy flag.
module hazard_div_seq
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic flush_i,
    input  logic start_i,
    output logic busy_o
);

    div_state_e state_q;
    logic [3:0] div_cnt_q;
    logic       busy_q;

    // Occupancy FSM: load DIV_CYCLES-1 on issue, release EXE when the count reaches 1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= DIV_IDLE;
            div_cnt_q <= 4'd0;
            busy_q    <= 1'b0;
        end else if (flush_i) begin
            state_q   <= DIV_IDLE;
            div_cnt_q <= 4'd0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_q   <= DIV_BUSY;
                        div_cnt_q <= 4'(DIV_CYCLES - 1);
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= DIV_IDLE;
                        div_cnt_q <= div_cnt_q;
                        busy_q    <= 1'b0;
                    end
                end
                DIV_BUSY: begin
                    div_cnt_q <= div_cnt_q - 4'd1;
                    if (div_cnt_q == 4'd1) begin
                        state_q <= DIV_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DIV_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= DIV_IDLE;
                    div_cnt_q <= 4'd0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage interlock: stalls on late-result producers in EXE/MEM and on an
// occupied divider; counts stall cycles for performance monitoring.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [GPR_AW-1:0] id_rs_addr,
    input  logic [GPR_AW-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wren,
    input  logic [GPR_AW-1:0] id_wt_addr,
    input  logic              id_wb_late,
    input  logic              id_is_div,
    output logic              id_stall,
    output logic              exe_stall,
    output logic              id_issue,
    output logic              div_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    late_rec_t        exe_late_q, exe_late_d;
    late_rec_t        mem_late_q, mem_late_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             div_busy_s;
    logic             exe_stall_s;
    logic             id_stall_s;
    logic             issue_s;
    logic             div_start_s;

    hazard_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (flush),
        .start_i (div_start_s),
        .busy_o  (div_busy_s)
    );

    // Stall/issue decode for the instruction currently in ID.
    always_comb begin
        exe_stall_s = div_busy_s & ~flush;
        id_stall_s  = id_valid & ~flush &
                      (late_hit(exe_late_q, id_rs_used, id_rs_addr, id_rt_used, id_rt_addr) |
                       late_hit(mem_late_q, id_rs_used, id_rs_addr, id_rt_used, id_rt_addr) |
                       exe_stall_s);
        issue_s     = id_valid & ~id_stall_s & ~flush;
        div_start_s = issue_s & id_is_div;
    end

    // Late-producer pipeline: a held EXE sends a bubble into MEM.
    always_comb begin
        exe_late_d = exe_late_q;
        mem_late_d = mem_late_q;
        if (flush) begin
            exe_late_d = '0;
            mem_late_d = '0;
        end else if (exe_stall_s) begin
            mem_late_d = '0;
        end else begin
            mem_late_d       = exe_late_q;
            exe_late_d.valid = issue_s & id_wren & id_wb_late & (id_wt_addr != 5'd0);
            exe_late_d.addr  = id_wt_addr;
        end
    end

    // Saturating stall counter; flush deliberately leaves it alone.
    always_comb begin
        if (id_stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_late_q  <= '0;
            mem_late_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            exe_late_q  <= exe_late_d;
            mem_late_q  <= mem_late_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_stall     = id_stall_s;
    assign exe_stall    = exe_stall_s;
    assign id_issue     = issue_s & ~reset;
    assign div_busy     = div_busy_s;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: load-use distances, divider
// occupancy, flush, counter saturation and asynchronous reset.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             id_valid;
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_wren;
    logic [4:0]       id_wt_addr;
    logic             id_wb_late;
    logic             id_is_div;
    logic             id_stall;
    logic             exe_stall;
    logic             id_issue;
    logic             div_busy;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks;
    int n_errors;

    hazard_ctrl #(
        .DIV_CYCLES (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_wren      (id_wren),
        .id_wt_addr   (id_wt_addr),
        .id_wb_late   (id_wb_late),
        .id_is_div    (id_is_div),
        .id_stall     (id_stall),
        .exe_stall    (exe_stall),
        .id_issue     (id_issue),
        .div_busy     (div_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic stall, input logic issue,
                       input logic estall, input logic busy);
        chk({tag, ".id_stall"},  {31'd0, id_stall},  {31'd0, stall});
        chk({tag, ".id_issue"},  {31'd0, id_issue},  {31'd0, issue});
        chk({tag, ".exe_stall"}, {31'd0, exe_stall}, {31'd0, estall});
        chk({tag, ".div_busy"},  {31'd0, div_busy},  {31'd0, busy});
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic wr,
                         input logic [4:0] wt, input logic late, input logic dv);
        id_valid   = v;
        id_rs_addr = rs;
        id_rs_used = rsu;
        id_rt_addr = rt;
        id_rt_used = rtu;
        id_wren    = wr;
        id_wt_addr = wt;
        id_wb_late = late;
        id_is_div  = dv;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] dst);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, dst, 1'b1, 1'b0);
        #2;
    endtask

    task automatic alu(input logic [4:0] dst, input logic [4:0] src);
        drive(1'b1, src, 1'b1, 5'd0, 1'b0, 1'b1, dst, 1'b0, 1'b0);
        #2;
    endtask

    task automatic rdr(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu);
        drive(1'b1, rs, rsu, rt, rtu, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
    endtask

    task automatic div_i();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #23;
        ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.cnt", 32'(stall_cycles), 32'd0);
        cyc();
        reset = 1'b0;

        // Load-use distance 1: two stall cycles.
        cyc(); load(5'd3);                   ctl("d1.ld", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd0, 1'b0);  ctl("d1.s1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd0, 1'b0);  ctl("d1.s2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd0, 1'b0);  ctl("d1.go", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("d1.cnt", 32'(stall_cycles), 32'd2);

        // Load-use distance 2: one stall cycle (reader uses rt).
        cyc(); load(5'd3);                   ctl("d2.ld", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); alu(5'd5, 5'd9);              ctl("d2.alu", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd0, 1'b0, 5'd3, 1'b1);  ctl("d2.s1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); rdr(5'd0, 1'b0, 5'd3, 1'b1);  ctl("d2.go", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("d2.cnt", 32'(stall_cycles), 32'd3);

        // $0 producer, ALU producer and unused source fields never stall.
        cyc(); load(5'd0);                   ctl("z.ld0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd0, 1'b1, 5'd0, 1'b1);  ctl("z.rd0", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); alu(5'd3, 5'd9);              ctl("z.alu", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd3, 1'b1);  ctl("z.rd3", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); load(5'd4);                   ctl("z.ld4", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd4, 1'b0, 5'd4, 1'b0);  ctl("z.nouse", 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back loads hit in EXE and MEM together: still 2 stall cycles.
        cyc(); load(5'd3);                   ctl("dbl.ld3", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); load(5'd4);                   ctl("dbl.ld4", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd4, 1'b1);  ctl("dbl.s1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd4, 1'b1);  ctl("dbl.s2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); rdr(5'd3, 1'b1, 5'd4, 1'b1);  ctl("dbl.go", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dbl.cnt", 32'(stall_cycles), 32'd5);

        // Divide behind a load: 7 busy cycles, MEM bubbles drop the load.
        cyc(); load(5'd6);                   ctl("dv.ld", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); div_i();                      ctl("dv.iss", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(); rdr(5'd6, 1'b1, 5'd0, 1'b0);
            ctl($sformatf("dv.b%0d", i), 1'b1, 1'b0, 1'b1, 1'b1);
        end
        cyc(); rdr(5'd6, 1'b1, 5'd0, 1'b0);  ctl("dv.done", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dv.cnt", 32'(stall_cycles), 32'd12);

        // Flush during divide with a load in MEM.
        cyc(); load(5'd7);                   ctl("fl.ld", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); div_i();                      ctl("fl.div", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); flush = 1'b1; rdr(5'd7, 1'b1, 5'd0, 1'b0);
        ctl("fl.now", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); flush = 1'b0; rdr(5'd7, 1'b1, 5'd0, 1'b0);
        ctl("fl.after", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl.cnt", 32'(stall_cycles), 32'd12);

        // Another divide drives the 4-bit counter into saturation.
        cyc(); div_i();                      ctl("sat.div", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(); alu(5'd8, 5'd9);
        end
        cyc(); alu(5'd8, 5'd9);              ctl("sat.done", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat.cnt", 32'(stall_cycles), 32'd15);

        // Asynchronous reset in the middle of a divide stall.
        cyc(); div_i();                      ctl("ar.div", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(); rdr(5'd8, 1'b1, 5'd0, 1'b0);  ctl("ar.stall", 1'b1, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        ctl("ar.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ar.cnt", 32'(stall_cycles), 32'd0);
        cyc(); reset = 1'b0; #2;
        ctl("ar.rel", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
